// File: rtl/ws2812_pixel_code.sv
// ws2812_pixel_code: multi-lane WS2812-style serial encoder.
// Takes a stream of pixel words (one DATA_WIDTH slice per lane) and shifts
// them out MSB first as pulse-width coded bits. All lanes share one bit timer.
// A word flagged "last" is followed by a latch gap of rst_cnt_in low cycles.
//
// Ports:
//   clk_in, rst_in          clock, synchronous active-high reset
//   pix_valid_in/ready_out  word handshake; pix_last_in marks end of frame
//   pix_data_in             lane c at [c*DATA_WIDTH +: DATA_WIDTH]
//   period/t0h/t1h_cnt_in   bit period and high times, in cycles
//   rst_cnt_in              latch (low) time, in cycles
//   bit_code_out            registered serial code, one bit per lane
//   frame_done_out          one-cycle pulse on the final latch cycle
//   busy_out                block is not idle

// One output lane: holds its shift register and registered code bit.
module ws2812_lane #(
  parameter int DATA_WIDTH = 24,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  adv,
  input  logic                  send_n,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [CNT_WIDTH-1:0]  cnt_n,
  input  logic [CNT_WIDTH-1:0]  t0h_n,
  input  logic [CNT_WIDTH-1:0]  t1h_n,
  output logic                  code
);
  logic [DATA_WIDTH-1:0] sh, sh_n;
  logic                  bit_n;

  // The output is computed from the *next* cycle's bit and cycle index so
  // that the registered code lines up with the cycle being entered.
  always_comb begin
    sh_n = sh;
    if (load)     sh_n = data;
    else if (adv) sh_n = sh << 1;
    bit_n = sh_n[DATA_WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh   <= '0;
      code <= 1'b0;
    end else begin
      sh   <= sh_n;
      code <= send_n && (cnt_n < (bit_n ? t1h_n : t0h_n));
    end
  end
endmodule

module ws2812_pixel_code #(
  parameter int CHANNELS   = 2,
  parameter int DATA_WIDTH = 24,
  parameter int CNT_WIDTH  = 8,
  parameter int RST_WIDTH  = 16
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           pix_valid_in,
  input  logic                           pix_last_in,
  input  logic [CHANNELS*DATA_WIDTH-1:0] pix_data_in,
  output logic                           pix_ready_out,
  input  logic [CNT_WIDTH-1:0]           period_cnt_in,
  input  logic [CNT_WIDTH-1:0]           t0h_cnt_in,
  input  logic [CNT_WIDTH-1:0]           t1h_cnt_in,
  input  logic [RST_WIDTH-1:0]           rst_cnt_in,
  output logic [CHANNELS-1:0]            bit_code_out,
  output logic                           frame_done_out,
  output logic                           busy_out
);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;
  state_t state, state_n;

  logic [CNT_WIDTH-1:0] cnt, cnt_n, pm1, t0h, t1h, t0h_n, t1h_n;
  logic [BW-1:0]        bidx, bidx_n;
  logic [RST_WIDTH-1:0] rlen, lcnt, lcnt_n;
  logic                 last;
  logic                 bit_end, pix_end, latch_end, ready, accept;
  logic                 load, adv, send_n;
  logic [CHANNELS-1:0]  code;

  always_comb begin
    bit_end   = (cnt == pm1);
    pix_end   = (state == SEND) && bit_end && (bidx == '0);
    latch_end = (state == LATCH) &&
                ((rlen == '0) || (lcnt == rlen - RST_WIDTH'(1)));
    // A word flagged last is followed by the latch gap, so no new word is
    // taken at the end of it.
    ready     = (state == IDLE) || (pix_end && !last);
    accept    = ready && pix_valid_in;

    state_n = state;
    cnt_n   = cnt;
    bidx_n  = bidx;
    lcnt_n  = lcnt;
    load    = 1'b0;
    adv     = 1'b0;

    case (state)
      IDLE: ;
      SEND: begin
        if (!bit_end) begin
          cnt_n = cnt + CNT_WIDTH'(1);
        end else if (bidx != '0) begin
          cnt_n  = '0;
          bidx_n = bidx - BW'(1);
          adv    = 1'b1;
        end else if (last) begin
          state_n = LATCH;
          lcnt_n  = '0;
        end else begin
          state_n = IDLE;
        end
      end
      LATCH: begin
        if (latch_end) state_n = IDLE;
        else           lcnt_n  = lcnt + RST_WIDTH'(1);
      end
      default: state_n = IDLE;
    endcase

    if (accept) begin
      state_n = SEND;
      cnt_n   = '0;
      bidx_n  = BW'(DATA_WIDTH - 1);
      load    = 1'b1;
      adv     = 1'b0;
    end

    send_n = (state_n == SEND);
    t0h_n  = load ? t0h_cnt_in : t0h;
    t1h_n  = load ? t1h_cnt_in : t1h;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      cnt   <= '0;
      bidx  <= '0;
      lcnt  <= '0;
      pm1   <= '0;
      t0h   <= '0;
      t1h   <= '0;
      rlen  <= '0;
      last  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bidx  <= bidx_n;
      lcnt  <= lcnt_n;
      if (load) begin
        // Period 0 behaves as period 1; store P-1 as the bit-end compare.
        pm1  <= (period_cnt_in == '0) ? '0 : period_cnt_in - CNT_WIDTH'(1);
        t0h  <= t0h_cnt_in;
        t1h  <= t1h_cnt_in;
        rlen <= rst_cnt_in;
        last <= pix_last_in;
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    ws2812_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .CNT_WIDTH (CNT_WIDTH)
    ) u_lane (
      .clk   (clk_in),
      .rst   (rst_in),
      .load  (load),
      .adv   (adv),
      .send_n(send_n),
      .data  (pix_data_in[c*DATA_WIDTH +: DATA_WIDTH]),
      .cnt_n (cnt_n),
      .t0h_n (t0h_n),
      .t1h_n (t1h_n),
      .code  (code[c])
    );
  end

  // Outputs are forced quiet for as long as reset is held.
  assign bit_code_out   = rst_in ? '0 : code;
  assign frame_done_out = latch_end && !rst_in;
  assign busy_out       = (state != IDLE) && !rst_in;
  assign pix_ready_out  = ready && !rst_in;
endmodule

// File: tb/tb_ws2812_pixel_code.sv
// Self-checking bench for ws2812_pixel_code. The expected waveform of a
// pixel is computed directly from its word and timing values (bit index and
// cycle-within-bit by division), independent of the design's counters.
module tb_ws2812_pixel_code;
  localparam int CH = 2, DW = 24, CW = 8, RW = 16;

  logic             clk = 1'b0, rst = 1'b1, valid = 1'b0, last = 1'b0;
  logic [CH*DW-1:0] data = '0;
  logic [CW-1:0]    per = '0, t0 = '0, t1 = '0;
  logic [RW-1:0]    rc = '0;
  logic             ready, done, busy;
  logic [CH-1:0]    code;
  int               ncmp = 0, nfail = 0;

  typedef struct packed {
    logic             valid;
    logic             last;
    logic [CH*DW-1:0] data;
    logic [CW-1:0]    per, t0, t1;
    logic [RW-1:0]    r;
  } px_t;

  always #5 clk = ~clk;

  ws2812_pixel_code #(.CHANNELS(CH), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .RST_WIDTH(RW)) dut (
    .clk_in(clk), .rst_in(rst), .pix_valid_in(valid), .pix_last_in(last),
    .pix_data_in(data), .pix_ready_out(ready), .period_cnt_in(per),
    .t0h_cnt_in(t0), .t1h_cnt_in(t1), .rst_cnt_in(rc),
    .bit_code_out(code), .frame_done_out(done), .busy_out(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Lane c is high at cycle i of a bit when i < (bit ? T1H : T0H).
  function automatic logic [CH-1:0] exp_code(input px_t p, input int j);
    int pp = (p.per == '0) ? 1 : int'(p.per);
    int b  = DW - 1 - j / pp;
    int i  = j % pp;
    logic [CH-1:0] res;
    for (int c = 0; c < CH; c++) begin
      int hi = p.data[c*DW + b] ? int'(p.t1) : int'(p.t0);
      res[c] = (i < hi);
    end
    return res;
  endfunction

  task automatic drive(input px_t p);
    valid = p.valid; last = p.last; data = p.data;
    per = p.per; t0 = p.t0; t1 = p.t1; rc = p.r;
  endtask

  task automatic scramble();
    valid = 1'($urandom); last = 1'($urandom);
    data = {16'($urandom), 32'($urandom)};
    per = CW'($urandom); t0 = CW'($urandom); t1 = CW'($urandom); rc = RW'($urandom);
  endtask

  function automatic px_t rand_px(input logic islast);
    px_t p;
    p.valid = 1'b1; p.last = islast;
    p.data  = {16'($urandom), 32'($urandom)};
    p.per   = CW'($urandom_range(0, 5));
    p.t0    = CW'($urandom_range(0, 7));
    p.t1    = CW'($urandom_range(0, 7));
    p.r     = RW'($urandom_range(0, 6));
    return p;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, " code"},  64'(code),  64'd0);
    chk({tag, " ready"}, 64'(ready), 64'd1);
    chk({tag, " busy"},  64'(busy),  64'd0);
    chk({tag, " done"},  64'(done),  64'd0);
  endtask

  task automatic do_reset_pulse();
    valid = 1'b0; rst = 1'b1; #1;
    chk("rst code",  64'(code),  64'd0);
    chk("rst ready", 64'(ready), 64'd0);
    chk("rst busy",  64'(busy),  64'd0);
    chk("rst done",  64'(done),  64'd0);
    @(posedge clk); #1;
    rst = 1'b0; #1;
    chk_idle("post_rst");
  endtask

  task automatic do_idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      chk_idle($sformatf("idle k=%0d", k));
    end
  endtask

  // Entered with cur offered and the design ready; leaves nxt driven during
  // the final cycle of the pixel. Timing inputs are scrambled in between.
  task automatic do_pixel(input px_t cur, input px_t nxt, input int abort_j);
    int n = DW * ((cur.per == '0) ? 1 : int'(cur.per));
    chk("accept ready", 64'(ready), 64'd1);
    for (int j = 0; j < n; j++) begin
      @(posedge clk); #1;
      chk($sformatf("code j=%0d", j),  64'(code),  64'(exp_code(cur, j)));
      chk($sformatf("ready j=%0d", j), 64'(ready), 64'((j == n - 1) && !cur.last));
      chk($sformatf("busy j=%0d", j),  64'(busy),  64'd1);
      chk($sformatf("done j=%0d", j),  64'(done),  64'd0);
      if (j == abort_j) begin
        do_reset_pulse();
        return;
      end
      if (j == n - 1) drive(nxt);
      else            scramble();
    end
  endtask

  task automatic do_latch(input logic [RW-1:0] r, input int abort_k);
    int n = (r == '0) ? 1 : int'(r);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      chk($sformatf("latch code k=%0d", k),  64'(code),  64'd0);
      chk($sformatf("latch ready k=%0d", k), 64'(ready), 64'd0);
      chk($sformatf("latch busy k=%0d", k),  64'(busy),  64'd1);
      chk($sformatf("latch done k=%0d", k),  64'(done),  64'(k == n - 1));
      if (k == abort_k) begin
        do_reset_pulse();
        return;
      end
      valid = (k == n - 1) ? 1'b0 : 1'($urandom);
    end
    @(posedge clk); #1;
    chk_idle("after_latch");
  endtask

  initial begin
    px_t z, a, e, f, g, h, cur, nx;
    px_t p [3];
    int  np;
    z = '0;

    // Reset state and release.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("in_rst code",  64'(code),  64'd0);
    chk("in_rst ready", 64'(ready), 64'd0);
    chk("in_rst busy",  64'(busy),  64'd0);
    chk("in_rst done",  64'(done),  64'd0);
    rst = 1'b0; #1;
    chk_idle("rst_release");

    // Single GRB pixel, P=10, T0H=3, T1H=7, R=50.
    a = '0; a.valid = 1'b1; a.last = 1'b1;
    a.data = {24'h00FF00, 24'hFF0000};
    a.per = 8'd10; a.t0 = 8'd3; a.t1 = 8'd7; a.r = 16'd50;
    drive(a); do_pixel(a, z, -1); do_latch(a.r, -1);

    // Three back-to-back pixels, last on the third.
    for (int i = 0; i < 3; i++) begin
      p[i] = rand_px(i == 2);
      p[i].per = 8'd10;
      p[i].t0  = CW'($urandom_range(0, 11));
      p[i].t1  = CW'($urandom_range(0, 11));
      p[i].r   = RW'($urandom_range(0, 20));
    end
    drive(p[0]);
    do_pixel(p[0], p[1], -1);
    do_pixel(p[1], p[2], -1);
    do_pixel(p[2], z, -1);
    do_latch(p[2].r, -1);

    // P=0, T0H=0, T1H=5 then a stalled source.
    e = rand_px(1'b0); e.per = 8'd0; e.t0 = 8'd0; e.t1 = 8'd5;
    drive(e); do_pixel(e, z, -1); do_idle(5);

    // Reset during bit 5 of SEND, then during LATCH.
    f = rand_px(1'b0); f.per = 8'd4;
    drive(f); do_pixel(f, z, (DW - 1 - 5) * 4 + 2); do_idle(3);
    g = rand_px(1'b1); g.per = 8'd1; g.r = 16'd20;
    drive(g); do_pixel(g, z, -1); do_latch(g.r, 7); do_idle(25);

    // R=0: the pulse lands in the cycle after the final bit.
    h = rand_px(1'b1); h.per = 8'd3; h.r = 16'd0;
    drive(h); do_pixel(h, z, -1); do_latch(h.r, -1);

    // Random frames of 1..3 pixels, ending with a latch or a stall.
    for (int fr = 0; fr < 8; fr++) begin
      logic fin_last;
      np = $urandom_range(1, 3);
      fin_last = 1'($urandom);
      cur = rand_px((np == 1) ? fin_last : 1'b0);
      drive(cur);
      for (int i = 0; i < np; i++) begin
        if (i == np - 1) nx = z;
        else             nx = rand_px((i + 1 == np - 1) ? fin_last : 1'b0);
        do_pixel(cur, nx, -1);
        if (i == np - 1) begin
          if (cur.last) do_latch(cur.r, -1);
          else          do_idle(2);
        end
        cur = nx;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
